// File: rtl/squared_mwi.sv
// Squaring + moving-window integration stage of the QRS pipeline.
// Squares each accepted sample, keeps a 2^WIN_LOG2-deep window and emits floor(sum/N).
module squared_mwi #(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_LOG2   = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] xin,
    output logic [2*DATA_WIDTH-1:0]      yout,
    output logic                         yvalid,
    output logic                         filled
);
    localparam int SW = 2*DATA_WIDTH;
    localparam int AW = SW + WIN_LOG2;
    localparam int N  = 1 << WIN_LOG2;

    // vld_pipe_q[0] is the stage-1 valid, vld_pipe_q[1] drives yvalid
    logic [1:0]                vld_pipe_q;
    logic [SW-1:0]             sq_q;
    logic signed [SW-1:0]      xin_ext;
    logic signed [SW-1:0]      prod;
    logic [SW-1:0]             win_q [N];
    logic [WIN_LOG2-1:0]       wptr_q;
    logic [WIN_LOG2:0]         cnt_q;
    logic [AW-1:0]             sum_q, sum_d;

    // Full-width signed product: -2^(DW-1) squared still fits as a positive value
    assign xin_ext = SW'(xin);
    assign prod    = xin_ext * xin_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sq_q       <= '0;
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], en};
            if (en) sq_q <= prod;
        end
    end

    // The evicted entry is always part of sum, so this never underflows
    assign sum_d = sum_q + AW'(sq_q) - AW'(win_q[wptr_q]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q  <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else if (vld_pipe_q[0]) begin
            sum_q  <= sum_d;
            wptr_q <= wptr_q + 1'b1;
            if (cnt_q != (WIN_LOG2+1)'(N)) cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_win
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                win_q[i] <= '0;
            else if (vld_pipe_q[0] && wptr_q == WIN_LOG2'(i))
                win_q[i] <= sq_q;
        end
    end

    assign yout   = sum_q[AW-1:WIN_LOG2];
    assign yvalid = vld_pipe_q[1];
    assign filled = (cnt_q == (WIN_LOG2+1)'(N));
endmodule

// File: doc/squared_mwi.md
# squared_mwi

Squaring and moving-window-integration stage of the QRS detection pipeline. It sits directly downstream of the derivative stage and consumes the derivative's signed output sample stream. Each accepted sample is squared, pushed into a circular window of 2^WIN_LOG2 entries, and added to a running sum. The block emits the window mean to the threshold/peak-detection stage.

## Interface
- DATA_WIDTH, 16: width of the signed input sample.
- WIN_LOG2, 5: log2 of the window length N; N = 2^WIN_LOG2; legal range 1..8.
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  sample strobe; xin is accepted on a rising clk edge when en=1.
- xin  in  DATA_WIDTH  signed derivative sample.
- yout  out  2*DATA_WIDTH  unsigned window mean, floor(sum/N).
- yvalid  out  1  one-cycle pulse: yout was updated by a new sample.
- filled  out  1  high once N samples have entered the window since reset.

## Operation
- Stage 1 (square): on an edge with en=1, sq_r <= xin*xin, computed as signed×signed. The result is stored as an unsigned 2*DATA_WIDTH value. s1_v <= en on every edge.
  - Max square = 2^(2*DATA_WIDTH-2), for xin = -2^(DATA_WIDTH-1). It must not wrap or sign-flip.
- Stage 2 (integrate): on an edge with s1_v=1:
  - sum <= sum + sq_r - buf[wptr]
  - buf[wptr] <= sq_r
  - wptr <= wptr+1, wrapping from N-1 to 0.
  - yvalid <= s1_v on every edge.
- Accumulator width is 2*DATA_WIDTH+WIN_LOG2 bits, unsigned. Subtraction never underflows because buf[wptr] is always part of sum. sum never overflows.
- yout = sum[2*DATA_WIDTH+WIN_LOG2-1 : WIN_LOG2], taken directly from the sum register. This is truncation, not rounding.
- Window buffer: N registers of 2*DATA_WIDTH bits. All are cleared by reset, so the first N outputs are the partial sum divided by N (ramp-up).
- fill counter: counts accepted stage-2 updates and saturates at N. filled = (count == N). filled stays high until reset.
- en=0: stage 1 holds sq_r; the next edge has s1_v=0, so stage 2, yout and filled hold. Gaps of any length are allowed. The window counts samples, not cycles.
- Reset mid-operation: asynchronously clears sq_r, s1_v, the buffer, sum, wptr, the counter, yvalid and filled. Samples in flight are discarded.
- Reset values: yout=0, yvalid=0, filled=0.
- rstn low dominates en.

## Timing
- Latency: xin accepted at edge k (en=1) → sum, yout and yvalid updated at edge k+1. yvalid is high for the one cycle after edge k+1.
- Throughput: one sample per clock. Back-to-back en=1 gives yvalid high continuously from edge 2 onward.
- filled rises at the same edge as the yvalid of the N-th accepted sample.
- First en=1 edge after rstn deassertion is accepted. rstn deassertion is synchronized externally.
- No combinational path from inputs to outputs.

## Test plan
- Reset values: hold rstn=0 with xin=1234, en=1 → yout=0, yvalid=0, filled=0. After release with en=0 for 10 cycles → outputs unchanged.
- Constant input, DATA_WIDTH=16, WIN_LOG2=5: xin=100, en=1 continuously.
  - k-th yvalid gives yout=floor(10000k/32); k=1 → 312, k=16 → 5000.
  - k=32 → 10000 with filled rising on the same edge. yout stays 10000 thereafter.
- Impulse: xin=1000 for one sample, then zeros → exactly 32 consecutive valid outputs of 31250, then 0. Verifies wrap and eviction.
- Extremes: xin=-32768 continuously → steady yout=2^30. Alternating ±32767 → steady yout=1073676289. No wrap.
- Strobe gaps: same stream as the constant test with en toggled pseudo-randomly (≥50% idle). yvalid count equals accepted samples. yout sequence is identical to the gap-free run; outputs hold between strobes.
- Reset mid-window: after 20 samples of 100, pulse rstn low for 1 cycle. Outputs clear immediately; the next sample of 100 gives yout=312, and filled stays 0 until 32 new samples.
